// File: rtl/timx_dtg_brk_nch.sv
// timx_dtg_brk_nch: N-channel complementary output stage with dead time, break filter and MOE control
module timx_dtg_brk_nch #(
    parameter int NCH     = 3,
    parameter int DTW     = 8,
    parameter int BK_FILT = 4
) (
    input  logic           apb_clk,
    input  logic           apb_rst,
    input  logic [NCH-1:0] ocref,
    input  logic [NCH-1:0] cc_e,
    input  logic [NCH-1:0] cc_ne,
    input  logic [NCH-1:0] cc_p,
    input  logic [NCH-1:0] cc_np,
    input  logic [NCH-1:0] ois,
    input  logic [NCH-1:0] oisn,
    input  logic [DTW-1:0] dtg,
    input  logic           ossr,
    input  logic           ossi,
    input  logic           bke,
    input  logic           bkp,
    input  logic           aoe,
    input  logic           bkin,
    input  logic           moe_set,
    input  logic           moe_clr,
    input  logic           update_ev,
    input  logic           bif_clr,
    output logic [NCH-1:0] ch_out,
    output logic [NCH-1:0] ch_out_en,
    output logic [NCH-1:0] chn_out,
    output logic [NCH-1:0] chn_out_en,
    output logic           moe,
    output logic           brk_active,
    output logic           bif
);
    localparam int FW = $clog2(BK_FILT + 1);
    logic [NCH-1:0] ref_q, raw, raw_n, ch_nx, chn_nx, en_nx, enn_nx;
    logic [DTW-1:0] cnt [NCH];
    logic [DTW-1:0] cnt_nx [NCH];
    logic [FW-1:0]  fcnt, fcnt_nx;
    logic [FW:0]    finc;
    logic           samp, brk_nx, moe_nx, bif_nx;
    always_comb begin
        samp    = (bkin == bkp) & bke;
        finc    = {1'b0, fcnt} + (FW+1)'(1);
        brk_nx  = brk_active;
        fcnt_nx = '0;
        if (!bke)
            brk_nx = 1'b0;
        else if (samp != brk_active) begin
            if (finc == (FW+1)'(BK_FILT))
                brk_nx = samp;
            else
                fcnt_nx = finc[FW-1:0];
        end
        // a pending or held break blocks moe_set, including the cycle it is released
        moe_nx = (brk_active | brk_nx | moe_clr) ? 1'b0 :
                 (moe_set | (aoe & update_ev))   ? 1'b1 : moe;
        bif_nx = (brk_nx & ~brk_active) | (bif & ~bif_clr);
    end
    always_comb begin
        cnt_nx = cnt;
        raw    = '0;
        raw_n  = '0;
        ch_nx  = '0;
        chn_nx = '0;
        en_nx  = '0;
        enn_nx = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_nx[i] = (ocref[i] != ref_q[i]) ? dtg :
                        (cnt[i] != '0)         ? cnt[i] - DTW'(1) : cnt[i];
            raw[i]    = (cc_e[i] & cc_ne[i]) ? ocref[i] & (cnt_nx[i] == '0) : ocref[i];
            raw_n[i]  = (cc_e[i] & cc_ne[i]) ? ~ocref[i] & (cnt_nx[i] == '0) : ocref[i];
            ch_nx[i]  = moe_nx ? (cc_e[i] ? raw[i] ^ cc_p[i] : cc_p[i]) : ois[i];
            chn_nx[i] = moe_nx ? (cc_ne[i] ? raw_n[i] ^ cc_np[i] : cc_np[i]) :
                                 oisn[i] & ~(cc_ne[i] & ois[i]);
            en_nx[i]  = moe_nx ? cc_e[i] | ossr : ossi;
            enn_nx[i] = moe_nx ? cc_ne[i] | ossr : ossi;
        end
    end
    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            ref_q      <= '0;
            cnt        <= '{default: '0};
            fcnt       <= '0;
            brk_active <= 1'b0;
            moe        <= 1'b0;
            bif        <= 1'b0;
            ch_out     <= '0;
            ch_out_en  <= '0;
            chn_out    <= '0;
            chn_out_en <= '0;
        end else begin
            ref_q      <= ocref;
            cnt        <= cnt_nx;
            fcnt       <= fcnt_nx;
            brk_active <= brk_nx;
            moe        <= moe_nx;
            bif        <= bif_nx;
            ch_out     <= ch_nx;
            ch_out_en  <= en_nx;
            chn_out    <= chn_nx;
            chn_out_en <= enn_nx;
        end
    end
endmodule

// File: tb/tb_timx_dtg_brk_nch.sv
// tb_timx_dtg_brk_nch: directed stimulus against an elapsed-time behavioural model plus literal checks
module tb_timx_dtg_brk_nch;
    localparam int NCH = 3, DTW = 8, BK_FILT = 4, BIG = 1 << 20;
    logic           apb_clk = 1'b0, apb_rst;
    logic [NCH-1:0] ocref, cc_e, cc_ne, cc_p, cc_np, ois, oisn;
    logic [DTW-1:0] dtg;
    logic           ossr, ossi, bke, bkp, aoe, bkin, moe_set, moe_clr, update_ev, bif_clr;
    logic [NCH-1:0] ch_out, ch_out_en, chn_out, chn_out_en;
    logic           moe, brk_active, bif;
    logic [NCH-1:0] e_ch, e_chen, e_chn, e_chnen, m_last;
    logic           e_moe, e_brk, e_bif;
    int             m_age [NCH];
    int             m_dtl [NCH];
    bit             m_hist[$];
    int             errors = 0, checks = 0;
    bit             chk_en = 0;

    timx_dtg_brk_nch #(.NCH(NCH), .DTW(DTW), .BK_FILT(BK_FILT)) dut (
        .apb_clk(apb_clk), .apb_rst(apb_rst), .ocref(ocref), .cc_e(cc_e), .cc_ne(cc_ne),
        .cc_p(cc_p), .cc_np(cc_np), .ois(ois), .oisn(oisn), .dtg(dtg), .ossr(ossr), .ossi(ossi),
        .bke(bke), .bkp(bkp), .aoe(aoe), .bkin(bkin), .moe_set(moe_set), .moe_clr(moe_clr),
        .update_ev(update_ev), .bif_clr(bif_clr), .ch_out(ch_out), .ch_out_en(ch_out_en),
        .chn_out(chn_out), .chn_out_en(chn_out_en), .moe(moe), .brk_active(brk_active), .bif(bif)
    );

    always #5 apb_clk = ~apb_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit s, all_diff, nb, settled;
        logic r, rn;
        if (apb_rst) begin
            m_last = '0;
            for (int i = 0; i < NCH; i++) begin
                m_age[i] = BIG;
                m_dtl[i] = 0;
            end
            m_hist.delete();
            {e_ch, e_chen, e_chn, e_chnen, e_moe, e_brk, e_bif} = '0;
            return;
        end
        s = (bkin == bkp) && bke;
        m_hist.push_back(s);
        if (m_hist.size() > BK_FILT) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == BK_FILT);
        foreach (m_hist[j]) if (m_hist[j] == e_brk) all_diff = 0;
        nb    = !bke ? 1'b0 : all_diff ? s : e_brk;
        e_moe = (e_brk || nb || moe_clr) ? 1'b0 : (moe_set || (aoe && update_ev)) ? 1'b1 : e_moe;
        e_bif = (nb && !e_brk) ? 1'b1 : bif_clr ? 1'b0 : e_bif;
        e_brk = nb;
        for (int i = 0; i < NCH; i++) begin
            if (ocref[i] !== m_last[i]) begin
                m_last[i] = ocref[i];
                m_age[i]  = 0;
                m_dtl[i]  = int'(dtg);
            end else if (m_age[i] < BIG) m_age[i]++;
            settled = m_age[i] >= m_dtl[i];
            if (cc_e[i] && cc_ne[i]) begin
                r  = ocref[i] && settled;
                rn = !ocref[i] && settled;
            end else begin
                r  = ocref[i];
                rn = ocref[i];
            end
            if (e_moe) begin
                e_ch[i]    = cc_e[i] ? r ^ cc_p[i] : cc_p[i];
                e_chn[i]   = cc_ne[i] ? rn ^ cc_np[i] : cc_np[i];
                e_chen[i]  = cc_e[i] | ossr;
                e_chnen[i] = cc_ne[i] | ossr;
            end else begin
                e_ch[i]    = ois[i];
                e_chn[i]   = (cc_ne[i] && ois[i] && oisn[i]) ? 1'b0 : oisn[i];
                e_chen[i]  = ossi;
                e_chnen[i] = ossi;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge apb_clk);
            model_step();
            #2;
        end
    endtask

    always @(negedge apb_clk) begin
        if (chk_en) begin
            chk("ch_out", ch_out, e_ch);
            chk("ch_out_en", ch_out_en, e_chen);
            chk("chn_out", chn_out, e_chn);
            chk("chn_out_en", chn_out_en, e_chnen);
            chk("moe", moe, e_moe);
            chk("brk_active", brk_active, e_brk);
            chk("bif", bif, e_bif);
        end
    end

    initial begin
        apb_rst = 1; ocref = '0; cc_e = '1; cc_ne = '1; cc_p = '0; cc_np = '0; ois = '0; oisn = '0;
        dtg = 8'd3; ossr = 0; ossi = 0; bke = 0; bkp = 1; aoe = 0; bkin = 0;
        moe_set = 0; moe_clr = 0; update_ev = 0; bif_clr = 0;
        tick(2);
        chk_en = 1;
        chk("lit_reset_out", {ch_out, chn_out, ch_out_en, chn_out_en, moe, brk_active, bif}, 0);
        apb_rst = 0;
        moe_set = 1; tick(); moe_set = 0;
        chk("lit_moe_set", moe, 1);
        chk("lit_idle_chn", chn_out, 3'b111);
        // dead time 3: chn0 drops at once, ch0 rises three edges later
        ocref = 3'b001; tick();
        chk("lit_dt_chn0_drop", chn_out, 3'b110);
        chk("lit_dt_ch0_wait", ch_out, 3'b000);
        tick(2);
        chk("lit_dt_ch0_k2", ch_out, 3'b000);
        tick();
        chk("lit_dt_ch0_rise", ch_out, 3'b001);
        // dead time 5 with a 3-clock pulse: ch1 never asserts
        dtg = 8'd5; ocref = 3'b011; tick(3);
        ocref = 3'b001; tick();
        chk("lit_glitch_ch1", ch_out, 3'b001);
        tick(4);
        chk("lit_glitch_chn1_low", chn_out, 3'b100);
        tick();
        chk("lit_glitch_chn1_high", chn_out, 3'b110);
        dtg = 8'd0; ocref = 3'b111; tick();
        chk("lit_dt0_ch", ch_out, 3'b111);
        chk("lit_dt0_chn", chn_out, 3'b000);
        cc_p = 3'b001; cc_np = 3'b010; tick();
        chk("lit_pol_ch", ch_out, 3'b110);
        chk("lit_pol_chn", chn_out, 3'b010);
        cc_p = '0; cc_np = 3'b001; cc_ne = 3'b110; cc_e = 3'b011; ossr = 1; tick();
        chk("lit_single_ch", ch_out, 3'b011);
        chk("lit_single_chnen", chn_out_en, 3'b111);
        ossr = 0; tick();
        chk("lit_ossr0_chnen", chn_out_en, 3'b110);
        chk("lit_ossr0_chen", ch_out_en, 3'b011);
        cc_e = '1; cc_ne = '1; cc_np = '0; tick();
        // break filter: 3 samples are not enough, 4 are
        bke = 1; bkin = 1; tick(3);
        bkin = 0; tick();
        chk("lit_brk_short", brk_active, 0);
        bkin = 1; tick(3);
        chk("lit_brk_3", brk_active, 0);
        tick();
        chk("lit_brk_on", {brk_active, bif, moe}, 3'b110);
        moe_set = 1; tick(); moe_set = 0;
        chk("lit_moe_set_blocked", moe, 0);
        ossi = 1; ois = 3'b101; oisn = 3'b010; tick();
        chk("lit_idle_ch", ch_out, 3'b101);
        chk("lit_idle_chn2", chn_out, 3'b010);
        chk("lit_idle_en", {ch_out_en, chn_out_en}, 6'b111111);
        ois = '1; oisn = '1; tick();
        chk("lit_idle_noshoot", chn_out, 3'b000);
        bkin = 0; tick(4);
        chk("lit_brk_off", brk_active, 0);
        update_ev = 1; tick(); update_ev = 0;
        chk("lit_aoe0", moe, 0);
        aoe = 1; update_ev = 1; tick(); update_ev = 0; aoe = 0;
        chk("lit_aoe1", moe, 1);
        moe_clr = 1; tick(); moe_clr = 0;
        chk("lit_moe_clr", moe, 0);
        moe_set = 1; tick(); moe_set = 0;
        bif_clr = 1; tick(); bif_clr = 0;
        chk("lit_bif_clr", bif, 0);
        bkin = 1; tick(3);
        bif_clr = 1; tick(); bif_clr = 0;
        chk("lit_bif_collide", {bif, brk_active}, 2'b11);
        bke = 0; tick();
        chk("lit_bke_off", brk_active, 0);
        moe_set = 1; tick(); moe_set = 0;
        chk("lit_moe_back", moe, 1);
        bkin = 0; dtg = 8'd10; ocref = 3'b110; tick(2);
        apb_rst = 1; tick();
        chk("lit_rst_mid_dt", {ch_out, chn_out, ch_out_en, chn_out_en, moe, brk_active, bif}, 0);
        apb_rst = 0; tick(3);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
